// File: rtl/riscv_pkg.sv
// Shared RV32I subset constants: opcodes, funct fields, ALU encodings and control FSM states.
// Pure definitions, no logic; imported by the decoder and the fetch/decode controller.
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        TRAP   = 2'd3
    } state_t;

endpackage

// File: rtl/rv_decoder.sv
// Combinational RV32I decoder for the R-type ALU subset and BEQ; zero latency.
// No handshake: outputs follow the instruction word directly.
module rv_decoder
    import riscv_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [3:0]  alu_control_o,
    output logic        is_rtype_o,
    output logic        is_beq_o,
    output logic        illegal_o,
    output logic [31:0] imm_b_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ir_i[6:0];
    assign funct3 = ir_i[14:12];
    assign funct7 = ir_i[31:25];

    assign rs1_o   = ir_i[19:15];
    assign rs2_o   = ir_i[24:20];
    assign rd_o    = ir_i[11:7];
    assign imm_b_o = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};

    always_comb begin
        alu_control_o = ALU_ADD;
        is_rtype_o    = 1'b0;
        is_beq_o      = 1'b0;
        illegal_o     = 1'b1;
        if (opcode == OP_RTYPE) begin
            is_rtype_o = 1'b1;
            illegal_o  = 1'b0;
            if (funct7 == F7_BASE) begin
                case (funct3)
                    F3_ADD_SUB: alu_control_o = ALU_ADD;
                    F3_AND:     alu_control_o = ALU_AND;
                    F3_OR:      alu_control_o = ALU_OR;
                    F3_SLT:     alu_control_o = ALU_SLT;
                    default: begin
                        is_rtype_o = 1'b0;
                        illegal_o  = 1'b1;
                    end
                endcase
            end else if (funct7 == F7_SUB && funct3 == F3_ADD_SUB) begin
                alu_control_o = ALU_SUB;
            end else begin
                is_rtype_o = 1'b0;
                illegal_o  = 1'b1;
            end
        end else if (opcode == OP_BRANCH && funct3 == F3_BEQ) begin
            // BEQ compares via subtraction; the datapath reports equality on zero.
            alu_control_o = ALU_SUB;
            is_beq_o      = 1'b1;
            illegal_o     = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode/exec controller: >=3 cycles per instruction, registered datapath controls.
// Fetch holds imem_req/imem_addr until imem_valid; an illegal opcode parks the FSM in TRAP until reset.
module fetch_decode_ctrl
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        zero,
    output logic [4:0]  read_reg_1,
    output logic [4:0]  read_reg_2,
    output logic [4:0]  write_reg,
    output logic [3:0]  alu_control,
    output logic        write_enable,
    output logic        illegal
);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] ir_q;
    logic        req_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic [3:0]  alu_q;
    logic        we_q;
    logic        illegal_q;

    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic [3:0]  dec_alu;
    logic        dec_is_rtype;
    logic        dec_is_beq;
    logic        dec_illegal;
    logic [31:0] dec_imm_b;

    rv_decoder u_decoder (
        .ir_i          (ir_q),
        .rs1_o         (dec_rs1),
        .rs2_o         (dec_rs2),
        .rd_o          (dec_rd),
        .alu_control_o (dec_alu),
        .is_rtype_o    (dec_is_rtype),
        .is_beq_o      (dec_is_beq),
        .illegal_o     (dec_illegal),
        .imm_b_o       (dec_imm_b)
    );

    // IR is held through EXEC, so the decoder still describes the current instruction there.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (dec_is_beq && zero) begin
            pc_d = pc_q + dec_imm_b;
        end
    end

    // req_q comes up one cycle after reset release, so a stale response from before reset is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
            req_q     <= 1'b0;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            rd_q      <= 5'd0;
            alu_q     <= 4'd0;
            we_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (req_q && imem_valid) begin
                        ir_q    <= imem_rdata;
                        req_q   <= 1'b0;
                        state_q <= DECODE;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                DECODE: begin
                    rs1_q <= dec_rs1;
                    rs2_q <= dec_rs2;
                    rd_q  <= dec_rd;
                    alu_q <= dec_alu;
                    if (dec_illegal) begin
                        we_q      <= 1'b0;
                        illegal_q <= 1'b1;
                        state_q   <= TRAP;
                    end else begin
                        we_q    <= dec_is_rtype && (dec_rd != 5'd0);
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    pc_q    <= pc_d;
                    we_q    <= 1'b0;
                    req_q   <= 1'b1;
                    state_q <= FETCH;
                end
                TRAP: begin
                    req_q     <= 1'b0;
                    we_q      <= 1'b0;
                    illegal_q <= 1'b1;
                end
            endcase
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = pc_q;
    assign read_reg_1   = rs1_q;
    assign read_reg_2   = rs2_q;
    assign write_reg    = rd_q;
    assign alu_control  = alu_q;
    assign write_enable = we_q;
    assign illegal      = illegal_q;

endmodule
